// File: rtl/blk_search_scheduler.sv
// Block-matching search scheduler: walks every (vertical, horizontal) search offset of each
// block in a frame, handshaking candidates to the matching datapath one per cycle.
module blk_search_scheduler #(
    parameter int unsigned SRCH_OFF_W = 48,
    parameter int unsigned SRCH_OFF_H = 1,
    parameter int unsigned NUM_BLKS   = 1200
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_i,
    input  logic        abort_i,
    input  logic        blk_ready_i,
    input  logic        issue_ready_i,
    output logic        issue_valid_o,
    output logic [15:0] coords_o,
    output logic [15:0] blk_index_o,
    output logic        last_coord_o,
    output logic        blk_done_o,
    output logic        frame_done_o,
    output logic        busy_o
);

    localparam logic [7:0]  HMax   = 8'(SRCH_OFF_W - 1);
    localparam logic [7:0]  VMax   = 8'(SRCH_OFF_H - 1);
    localparam logic [15:0] BlkMax = 16'(NUM_BLKS - 1);

    typedef enum logic [1:0] {StIdle, StWaitBlk, StIssue, StDone} state_e;

    state_e      state_q, state_d;
    logic [7:0]  h_q, h_d;
    logic [7:0]  v_q, v_d;
    logic [15:0] blk_q, blk_d;
    logic        blk_done_q, blk_done_d;

    logic        last_hit;
    logic        accept;

    assign last_hit = (h_q == HMax) && (v_q == VMax);
    // Abort wins over a handshake that completes in the same cycle.
    assign accept   = issue_valid_o && issue_ready_i && !abort_i;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (abort_i) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle:    if (start_i) state_d = StWaitBlk;
                StWaitBlk: if (blk_ready_i) state_d = StIssue;
                StIssue: begin
                    if (accept && last_hit) begin
                        state_d = (blk_q == BlkMax) ? StDone : StWaitBlk;
                    end
                end
                StDone:    state_d = StIdle;
                default:   state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        h_d        = h_q;
        v_d        = v_q;
        blk_d      = blk_q;
        blk_done_d = 1'b0;
        if (abort_i) begin
            h_d = 8'd0;
            v_d = 8'd0;
        end else if (state_q == StIdle && start_i) begin
            h_d   = 8'd0;
            v_d   = 8'd0;
            blk_d = 16'd0;
        end else if (accept) begin
            if (h_q == HMax) begin
                h_d = 8'd0;
                v_d = last_hit ? 8'd0 : v_q + 8'd1;
            end else begin
                h_d = h_q + 8'd1;
            end
            if (last_hit) begin
                blk_done_d = 1'b1;
                if (blk_q != BlkMax) blk_d = blk_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            h_q        <= 8'd0;
            v_q        <= 8'd0;
            blk_q      <= 16'd0;
            blk_done_q <= 1'b0;
        end else begin
            h_q        <= h_d;
            v_q        <= v_d;
            blk_q      <= blk_d;
            blk_done_q <= blk_done_d;
        end
    end

    // Outputs are forced low combinationally so reset overrides them within its own cycle.
    always_comb begin
        issue_valid_o = 1'b0;
        coords_o      = 16'd0;
        blk_index_o   = 16'd0;
        last_coord_o  = 1'b0;
        blk_done_o    = 1'b0;
        frame_done_o  = 1'b0;
        busy_o        = 1'b0;
        if (!reset) begin
            issue_valid_o = (state_q == StIssue);
            coords_o      = {v_q, h_q};
            blk_index_o   = blk_q;
            last_coord_o  = (state_q == StIssue) && last_hit;
            blk_done_o    = blk_done_q;
            frame_done_o  = (state_q == StDone) && !abort_i;
            busy_o        = (state_q != StIdle);
        end
    end

endmodule

// File: tb/tb_blk_search_scheduler.sv
// Directed bench: a 4x2 offset, 3-block instance for the main scenarios and a 1x1, 1-block
// instance for the degenerate frame.
module tb_blk_search_scheduler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, start, abort, blk_ready, issue_ready;
    logic        issue_valid, last_coord, blk_done, frame_done, busy;
    logic [15:0] coords, blk_index;

    logic        s_reset, s_start, s_abort, s_blk_ready, s_issue_ready;
    logic        s_issue_valid, s_last_coord, s_blk_done, s_frame_done, s_busy;
    logic [15:0] s_coords, s_blk_index;

    int total = 0;
    int bad   = 0;

    blk_search_scheduler #(
        .SRCH_OFF_W(4),
        .SRCH_OFF_H(2),
        .NUM_BLKS  (3)
    ) u_dut (
        .clk          (clk),
        .reset        (reset),
        .start_i      (start),
        .abort_i      (abort),
        .blk_ready_i  (blk_ready),
        .issue_ready_i(issue_ready),
        .issue_valid_o(issue_valid),
        .coords_o     (coords),
        .blk_index_o  (blk_index),
        .last_coord_o (last_coord),
        .blk_done_o   (blk_done),
        .frame_done_o (frame_done),
        .busy_o       (busy)
    );

    blk_search_scheduler #(
        .SRCH_OFF_W(1),
        .SRCH_OFF_H(1),
        .NUM_BLKS  (1)
    ) u_small (
        .clk          (clk),
        .reset        (s_reset),
        .start_i      (s_start),
        .abort_i      (s_abort),
        .blk_ready_i  (s_blk_ready),
        .issue_ready_i(s_issue_ready),
        .issue_valid_o(s_issue_valid),
        .coords_o     (s_coords),
        .blk_index_o  (s_blk_index),
        .last_coord_o (s_last_coord),
        .blk_done_o   (s_blk_done),
        .frame_done_o (s_frame_done),
        .busy_o       (s_busy)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_valid"}, 32'(issue_valid), 0);
        check_eq({tag, "_coords"}, 32'(coords), 0);
        check_eq({tag, "_blk"}, 32'(blk_index), 0);
        check_eq({tag, "_last"}, 32'(last_coord), 0);
        check_eq({tag, "_bdone"}, 32'(blk_done), 0);
        check_eq({tag, "_fdone"}, 32'(frame_done), 0);
        check_eq({tag, "_busy"}, 32'(busy), 0);
    endtask

    initial begin
        int idx, ndone, fd_cycle, b, v, h;
        logic spurious;

        reset = 1'b1; start = 1'b0; abort = 1'b0; blk_ready = 1'b0; issue_ready = 1'b0;
        s_reset = 1'b1; s_start = 1'b0; s_abort = 1'b0; s_blk_ready = 1'b0;
        s_issue_ready = 1'b0;
        tick;
        tick;
        check_all_zero("rst");
        reset = 1'b0;
        tick;
        check_eq("idle_busy", 32'(busy), 0);

        // Full frame, no backpressure.
        blk_ready = 1'b1; issue_ready = 1'b1; start = 1'b1;
        idx = 0; ndone = 0; fd_cycle = -1;
        for (int n = 1; n <= 32; n++) begin
            tick;
            start = 1'b0;
            if (issue_valid) begin
                if (idx < 24) begin
                    b = idx / 8;
                    v = (idx % 8) / 4;
                    h = idx % 4;
                    check_eq("a_coords", 32'(coords), 32'(v * 256 + h));
                    check_eq("a_blk", 32'(blk_index), 32'(b));
                    check_eq("a_last", 32'(last_coord), 32'(idx % 8 == 7));
                end
                idx++;
            end
            if (blk_done) ndone++;
            if (frame_done) fd_cycle = n;
            if (n == 10 || n == 19) check_eq("a_bubble", 32'(issue_valid), 0);
        end
        check_eq("a_count", 32'(idx), 24);
        check_eq("a_ndone", 32'(ndone), 3);
        check_eq("a_fd_cycle", 32'(fd_cycle), 28);
        check_eq("a_busy_after", 32'(busy), 0);
        check_eq("a_blk_after", 32'(blk_index), 2);

        // Backpressure at 0x0102.
        start = 1'b1;
        tick;
        start = 1'b0;
        repeat (7) tick;
        check_eq("b_at102", 32'(coords), 32'h0102);
        issue_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check_eq("b_hold_coords", 32'(coords), 32'h0102);
            check_eq("b_hold_blk", 32'(blk_index), 0);
            check_eq("b_hold_last", 32'(last_coord), 0);
            check_eq("b_hold_valid", 32'(issue_valid), 1);
            tick;
        end
        issue_ready = 1'b1;
        check_eq("b_rise_coords", 32'(coords), 32'h0102);
        tick;
        check_eq("b_next_coords", 32'(coords), 32'h0103);
        check_eq("b_next_last", 32'(last_coord), 1);

        // blk_ready withheld after block 0.
        blk_ready = 1'b0;
        tick;
        for (int i = 0; i < 10; i++) begin
            check_eq("c_wait_valid", 32'(issue_valid), 0);
            check_eq("c_wait_blk", 32'(blk_index), 1);
            check_eq("c_wait_bdone", 32'(blk_done), 32'(i == 0));
            tick;
        end
        blk_ready = 1'b1;
        tick;
        check_eq("c_resume_valid", 32'(issue_valid), 1);
        check_eq("c_resume_coords", 32'(coords), 0);
        check_eq("c_resume_blk", 32'(blk_index), 1);

        // Abort in block 1 at 0x0001 with issue_ready high.
        tick;
        check_eq("d_pre_coords", 32'(coords), 32'h0001);
        abort = 1'b1;
        tick;
        abort = 1'b0;
        check_eq("d_busy", 32'(busy), 0);
        check_eq("d_valid", 32'(issue_valid), 0);
        check_eq("d_coords", 32'(coords), 0);
        check_eq("d_bdone", 32'(blk_done), 0);
        check_eq("d_fdone", 32'(frame_done), 0);
        spurious = 1'b0;
        repeat (3) begin
            tick;
            spurious = spurious | blk_done | frame_done | issue_valid | busy;
        end
        check_eq("d_quiet", 32'(spurious), 0);
        start = 1'b1;
        tick;
        start = 1'b0;
        check_eq("d_restart_busy", 32'(busy), 1);
        check_eq("d_restart_blk", 32'(blk_index), 0);
        check_eq("d_restart_wait", 32'(issue_valid), 0);
        tick;
        check_eq("d_restart_valid", 32'(issue_valid), 1);
        check_eq("d_restart_coords", 32'(coords), 0);

        // start while busy is ignored; then reset mid-block.
        tick;
        tick;
        check_eq("e_at002", 32'(coords), 32'h0002);
        start = 1'b1;
        tick;
        start = 1'b0;
        check_eq("e_ign_coords", 32'(coords), 32'h0003);
        check_eq("e_ign_valid", 32'(issue_valid), 1);
        check_eq("e_ign_blk", 32'(blk_index), 0);
        reset = 1'b1;
        tick;
        check_all_zero("e_rst");
        reset = 1'b0;
        spurious = 1'b0;
        repeat (6) begin
            tick;
            spurious = spurious | issue_valid | busy | blk_done | frame_done;
        end
        check_eq("e_no_issue", 32'(spurious), 0);

        // start together with abort is ignored.
        start = 1'b1; abort = 1'b1;
        tick;
        start = 1'b0; abort = 1'b0;
        check_eq("f_busy", 32'(busy), 0);
        tick;
        check_eq("f_busy2", 32'(busy), 0);
        check_eq("f_valid2", 32'(issue_valid), 0);

        // Degenerate 1x1 offsets, single block.
        s_reset = 1'b0; s_blk_ready = 1'b1; s_issue_ready = 1'b1;
        tick;
        check_eq("g_idle", 32'(s_busy), 0);
        s_start = 1'b1;
        tick;
        s_start = 1'b0;
        check_eq("g_wait_valid", 32'(s_issue_valid), 0);
        check_eq("g_wait_busy", 32'(s_busy), 1);
        tick;
        check_eq("g_iss_valid", 32'(s_issue_valid), 1);
        check_eq("g_iss_coords", 32'(s_coords), 0);
        check_eq("g_iss_last", 32'(s_last_coord), 1);
        check_eq("g_iss_bdone", 32'(s_blk_done), 0);
        tick;
        check_eq("g_bdone", 32'(s_blk_done), 1);
        check_eq("g_fdone", 32'(s_frame_done), 1);
        check_eq("g_done_valid", 32'(s_issue_valid), 0);
        tick;
        check_eq("g_after_busy", 32'(s_busy), 0);
        check_eq("g_after_fdone", 32'(s_frame_done), 0);
        check_eq("g_after_bdone", 32'(s_blk_done), 0);
        check_eq("g_after_blk", 32'(s_blk_index), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
